irq_aggregator: RTL and testbench

Memory-mapped interrupt aggregator downstream of the system interval timer and the other Avalon peripherals. Collects up to 16 peripheral interrupt lines, latches and masks them, and presents one registered interrupt plus a priority-encoded vector to the CPU. Software reads status, acknowledges and force-triggers through a 16-bit Avalon-MM slave with the same register conventions as the timer.

---
 rtl/irq_aggregator_pkg.sv | 14 +
 rtl/irq_aggregator_prio_enc.sv | 25 ++
 rtl/irq_aggregator.sv | 119 +++++++++++
 tb/tb_irq_aggregator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_aggregator_pkg.sv
// rtl/irq_aggregator_pkg.sv - shared constants for the interrupt aggregator
// Purpose: register word addresses, maximum line count and vector width.
// Ports: none (package).
package irq_aggregator_pkg;
  localparam int MAX_IRQ = 16;
  localparam int VEC_W   = 4;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd2;
  localparam logic [2:0] ADDR_VECTOR   = 3'd3;
  localparam logic [2:0] ADDR_FORCE    = 3'd4;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;
endpackage

// File: rtl/irq_aggregator_prio_enc.sv
// rtl/irq_aggregator_prio_enc.sv - lowest-index-wins priority encoder
// Purpose: combinational encoder over MAX_IRQ request bits, bit 0 highest priority.
// Ports: req (in, MAX_IRQ) request bits; valid (out) any bit set;
//        index (out, VEC_W) lowest set bit, 0 when none.
module irq_aggregator_prio_enc
  import irq_aggregator_pkg::*;
(
  input  logic [MAX_IRQ-1:0] req,
  output logic               valid,
  output logic [VEC_W-1:0]   index
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// rtl/irq_aggregator.sv - memory-mapped interrupt aggregator with priority vector
// Purpose: latches, masks and prioritises up to 16 interrupt lines behind a
//          16-bit Avalon-MM slave; drives one registered irq and its vector.
// Ports: clk, reset_n (async, active-low); address, chipselect, write_n,
//        writedata, readdata (register slave, 1-cycle registered read);
//        irq_in (NUM_IRQ lines, active-high); irq_out, irq_vector (registered).
// Build option: IRQ_AGGREGATOR_EDGE_EN enables EDGE_SEL and edge capture;
//               without it every line is level-sensitive.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [VEC_W-1:0]   irq_vector
);

  // Bits above NUM_IRQ are held at zero in every register.
  localparam logic [MAX_IRQ-1:0] USED = MAX_IRQ'((32'd1 << NUM_IRQ) - 32'd1);

  logic [MAX_IRQ-1:0] irq_ext;
  logic [MAX_IRQ-1:0] irq_q;
  logic [MAX_IRQ-1:0] mask_r;
  logic [MAX_IRQ-1:0] force_r;
  logic [MAX_IRQ-1:0] pending;
  logic [MAX_IRQ-1:0] active;
  logic [MAX_IRQ-1:0] clr;
  logic [MAX_IRQ-1:0] ack_line;
  logic [15:0]        rd_mux;
  logic               wr_en;
  logic               act_valid;
  logic [VEC_W-1:0]   act_idx;

  assign irq_ext  = MAX_IRQ'(irq_in);
  assign wr_en    = chipselect && !write_n;
  assign ack_line = MAX_IRQ'(1) << irq_vector;
  assign active   = pending & mask_r;

  // Clear vector shared by STATUS W1C and the VECTOR ack-highest write;
  // the ack targets the line currently presented to the CPU.
  always_comb begin
    clr = '0;
    if (wr_en && address == ADDR_STATUS) clr = writedata & USED;
    if (wr_en && address == ADDR_VECTOR && irq_out) clr = ack_line;
  end

`ifdef IRQ_AGGREGATOR_EDGE_EN
  logic [MAX_IRQ-1:0] edge_pend;
  logic [MAX_IRQ-1:0] edge_sel;
  logic [MAX_IRQ-1:0] sel_chg;
  logic [MAX_IRQ-1:0] rise;

  assign rise    = irq_ext & ~irq_q;
  assign sel_chg = (wr_en && address == ADDR_EDGE_SEL) ? (edge_sel ^ (writedata & USED)) : '0;
  assign pending = (edge_sel & edge_pend) | (~edge_sel & irq_q) | force_r;

  // A new rising edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_pend <= '0;
      edge_sel  <= '0;
    end else begin
      edge_pend <= (edge_pend & ~clr & ~sel_chg) | (rise & edge_sel);
      if (wr_en && address == ADDR_EDGE_SEL) edge_sel <= writedata & USED;
    end
  end
`else
  assign pending = irq_q | force_r;
`endif

  irq_aggregator_prio_enc u_prio_enc (
    .req   (active),
    .valid (act_valid),
    .index (act_idx)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:   rd_mux = pending;
      ADDR_MASK:     rd_mux = mask_r;
      ADDR_ACTIVE:   rd_mux = active;
      ADDR_VECTOR:   rd_mux = {irq_out, 11'b0, irq_vector};
      ADDR_FORCE:    rd_mux = force_r;
`ifdef IRQ_AGGREGATOR_EDGE_EN
      ADDR_EDGE_SEL: rd_mux = edge_sel;
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q      <= '0;
      mask_r     <= '0;
      force_r    <= '0;
      readdata   <= '0;
      irq_out    <= 1'b0;
      irq_vector <= '0;
    end else begin
      irq_q      <= irq_ext;
      readdata   <= rd_mux;
      irq_out    <= act_valid;
      irq_vector <= act_valid ? act_idx : '0;
      if (wr_en && address == ADDR_MASK) mask_r <= writedata & USED;
      if (wr_en && address == ADDR_FORCE) force_r <= writedata & USED;
      else                                force_r <= force_r & ~clr;
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// tb/tb_irq_aggregator.sv - self-checking bench for irq_aggregator
module tb_irq_aggregator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [15:0] irq_in = '0;
  logic        irq_out;
  logic [3:0]  irq_vector;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];

  irq_aggregator #(.NUM_IRQ(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] e, input string t);
    exp_t x;
    x.addr = a; x.exp = e; x.tag = t;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    exp_t e; logic [15:0] got;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq_out: got %b want 0", irq_out); end
    n_chk++; if (irq_vector !== 4'd0) begin n_fail++; $display("FAIL reset_vector: got %0d want 0", irq_vector); end
    for (int a = 0; a < 8; a++) push(3'(a), 16'h0000, "reset_reg");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.tag, e.addr, got, e.exp); end
    end
  endtask

  task automatic test_level();
    wr(3'd1, 16'h0001);
    irq_in = 16'h0001;
    tick();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_latency_k: got %b want 0", irq_out); end
    tick();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL level_assert: got %b want 1", irq_out); end
    n_chk++; if (irq_vector !== 4'd0) begin n_fail++; $display("FAIL level_vector: got %0d want 0", irq_vector); end
    irq_in = 16'h0000;
    tick();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL level_hold: got %b want 1", irq_out); end
    tick();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_deassert: got %b want 0", irq_out); end
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_priority();
    exp_t e; logic [15:0] got;
    wr(3'd1, 16'h00FF);
    irq_in = 16'h000A;
    tick(); tick();
    n_chk++; if (irq_vector !== 4'd1) begin n_fail++; $display("FAIL prio_vec1: got %0d want 1", irq_vector); end
    wr(3'd3, 16'hFFFF);
    tick();
    n_chk++; if (irq_vector !== 4'd1 || irq_out !== 1'b1) begin n_fail++; $display("FAIL prio_ack_level: got %b/%0d want 1/1", irq_out, irq_vector); end
    irq_in = 16'h0008;
    tick(); tick();
    n_chk++; if (irq_vector !== 4'd3) begin n_fail++; $display("FAIL prio_vec3: got %0d want 3", irq_vector); end
    push(3'd0, 16'h0008, "prio_status");
    push(3'd2, 16'h0008, "prio_active");
    push(3'd3, 16'h8003, "prio_vector_reg");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    end
    irq_in = 16'h0000;
    tick(); tick();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", irq_out); end
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_force();
    exp_t e; logic [15:0] got;
    wr(3'd4, 16'h8000);
    wr(3'd1, 16'h8000);
    tick();
    n_chk++; if (irq_out !== 1'b1 || irq_vector !== 4'd15) begin n_fail++; $display("FAIL force_vec15: got %b/%0d want 1/15", irq_out, irq_vector); end
    push(3'd3, 16'h800F, "force_vector_reg");
    e = sb.pop_front(); rd(e.addr, got); n_chk++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    wr(3'd3, 16'h0000);
    push(3'd4, 16'h0000, "force_after_ack");
    e = sb.pop_front(); rd(e.addr, got); n_chk++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL force_ack_irq: got %b want 0", irq_out); end
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_mask();
    exp_t e; logic [15:0] got;
    wr(3'd4, 16'h0001);
    wr(3'd1, 16'h0000);
    push(3'd2, 16'h0000, "mask_active");
    push(3'd0, 16'h0001, "mask_status");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq_out); end
    wr(3'd1, 16'h0001);
    tick();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mask_reenable: got %b want 1", irq_out); end
    wr(3'd1, 16'h0000);
    tick();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mask_drop: got %b want 0", irq_out); end
    wr(3'd0, 16'h0001);
    wr(3'd6, 16'hFFFF);
    wr(3'd7, 16'hFFFF);
    push(3'd4, 16'h0000, "w1c_force");
    push(3'd0, 16'h0000, "w1c_status");
    push(3'd6, 16'h0000, "addr6");
    push(3'd7, 16'h0000, "addr7");
`ifndef IRQ_AGGREGATOR_EDGE_EN
    wr(3'd5, 16'hFFFF);
    push(3'd5, 16'h0000, "addr5_absent");
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    end
  endtask

`ifdef IRQ_AGGREGATOR_EDGE_EN
  task automatic test_edge();
    exp_t e; logic [15:0] got;
    wr(3'd5, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in = 16'h0004;
    tick();
    irq_in = 16'h0000;
    repeat (3) tick();
    n_chk++; if (irq_out !== 1'b1 || irq_vector !== 4'd2) begin n_fail++; $display("FAIL edge_irq: got %b/%0d want 1/2", irq_out, irq_vector); end
    push(3'd0, 16'h0004, "edge_status");
    push(3'd5, 16'h0004, "edge_sel_reg");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    end
    wr(3'd0, 16'h0004);
    push(3'd0, 16'h0000, "edge_w1c");
    e = sb.pop_front(); rd(e.addr, got); n_chk++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL edge_w1c_irq: got %b want 0", irq_out); end
    irq_in = 16'h0004;
    wr(3'd0, 16'h0004);
    irq_in = 16'h0000;
    push(3'd0, 16'h0004, "edge_set_wins");
    e = sb.pop_front(); rd(e.addr, got); n_chk++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    wr(3'd5, 16'h0000);
    wr(3'd5, 16'h0004);
    push(3'd0, 16'h0000, "edge_sel_change_clears");
    e = sb.pop_front(); rd(e.addr, got); n_chk++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, got, e.exp); end
    wr(3'd5, 16'h0000);
    wr(3'd1, 16'h0000);
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e; logic [15:0] got;
    wr(3'd4, 16'h0003);
    wr(3'd1, 16'h0003);
    address = 3'd1;
    tick();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", irq_out); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (irq_out !== 1'b0 || irq_vector !== 4'd0) begin n_fail++; $display("FAIL mid_async_out: got %b/%0d want 0/0", irq_out, irq_vector); end
    n_chk++; if (readdata !== 16'h0000) begin n_fail++; $display("FAIL mid_async_readdata: got %h want 0", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) push(3'(a), 16'h0000, "mid_reg");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd(e.addr, got); n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.tag, e.addr, got, e.exp); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_force();
    test_mask();
`ifdef IRQ_AGGREGATOR_EDGE_EN
    test_edge();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
